// File: rtl/axis_pattern_gen_if.sv
// AXI-Stream bundle between the pattern source and the S2MM slave.
interface axis_pattern_gen_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0]   tdata;
    logic                tvalid;
    logic                tready;
    logic                tlast;
    logic [DATA_W/8-1:0] tkeep;

    modport master (output tdata, tvalid, tlast, tkeep, input tready);
    modport slave  (input tdata, tvalid, tlast, tkeep, output tready);
endinterface

// File: rtl/axis_pattern_gen.sv
// AXI-Stream test-pattern source: fixed-length frames of COUNT, PRBS or CONST data,
// gated by the S2MM channel-running flag.
module axis_pattern_gen #(
    parameter int          DATA_W          = 32,
    parameter int          WORDS_PER_BLOCK = 4096,
    parameter logic [31:0] FILL            = 32'hAAAAAA00,
    parameter logic [31:0] SEED            = 32'h00000001
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                s2mm_prmry_resetn,
    input  logic [1:0]          cfg_mode,
    input  logic [31:0]         cfg_num_frames,
    input  logic [15:0]         cfg_gap,
    axis_pattern_gen_if.master  m,
    output logic                busy,
    output logic                done,
    output logic [31:0]         frames_sent
);
    // state | meaning
    // IDLE  | channel just enabled; latch cfg, present beat 0 next
    // RUN   | presenting beats, tvalid high
    // GAP   | inter-frame idle, tvalid low for cfg_gap cycles
    // DONE  | requested frame count sent, wait for channel reset
    typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;

    localparam int          LANES    = DATA_W / 32;
    localparam logic [31:0] LAST_IDX = 32'(WORDS_PER_BLOCK - 1);

    state_t      state;
    logic [1:0]  mode_q;
    logic [31:0] nframes_q;
    logic [15:0] gap_q;
    logic [15:0] gap_cnt;
    logic [31:0] word_idx;
    logic [31:0] frame_idx;
    logic [31:0] lfsr;

    logic        hs;
    logic        run_end;
    logic [31:0] lfsr_nxt;
    logic [31:0] word_nxt;
    logic [31:0] frame_nxt;
    logic [31:0] fs_nxt;

    function automatic logic [DATA_W-1:0] beat(input logic [1:0] md, input logic [7:0] f,
                                               input logic [15:0] w, input logic [31:0] r);
        logic [DATA_W-1:0] d;
        logic [63:0]       rr;
        d = '0;
        for (int i = 0; i < LANES; i++) begin
            rr = {r, r} << (8 * i);
            case (md)
                2'd1:    d[32*i +: 32] = rr[63:32];
                2'd2:    d[32*i +: 32] = FILL;
                default: d[32*i +: 32] = {f, 8'(i), w};
            endcase
        end
        return d;
    endfunction

    assign hs        = m.tvalid & m.tready;
    assign lfsr_nxt  = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
    assign word_nxt  = word_idx + 32'd1;
    assign frame_nxt = frame_idx + 32'd1;
    assign fs_nxt    = frames_sent + 32'd1;
    assign run_end   = (nframes_q != 32'd0) && (fs_nxt == nframes_q);
    assign busy      = (state == RUN) || (state == GAP);
    assign m.tkeep   = '1;

    always_ff @(posedge aclk) begin
        if (!aresetn || !s2mm_prmry_resetn) begin
            state       <= IDLE;
            m.tvalid    <= 1'b0;
            m.tlast     <= 1'b0;
            m.tdata     <= '0;
            word_idx    <= '0;
            frame_idx   <= '0;
            lfsr        <= SEED;
            frames_sent <= '0;
            done        <= 1'b0;
            gap_cnt     <= '0;
            mode_q      <= '0;
            nframes_q   <= '0;
            gap_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    mode_q    <= cfg_mode;
                    nframes_q <= cfg_num_frames;
                    gap_q     <= cfg_gap;
                    state     <= RUN;
                    m.tvalid  <= 1'b1;
                    m.tdata   <= beat(cfg_mode, 8'd0, 16'd0, lfsr);
                    m.tlast   <= (LAST_IDX == 32'd0);
                end
                RUN: begin
                    if (hs) begin
                        lfsr <= lfsr_nxt;
                        if (word_idx != LAST_IDX) begin
                            word_idx <= word_nxt;
                            m.tdata  <= beat(mode_q, frame_idx[7:0], word_nxt[15:0], lfsr_nxt);
                            m.tlast  <= (word_nxt == LAST_IDX);
                        end else begin
                            word_idx    <= '0;
                            frame_idx   <= frame_nxt;
                            frames_sent <= fs_nxt;
                            if (run_end) begin
                                state    <= DONE;
                                done     <= 1'b1;
                                m.tvalid <= 1'b0;
                                m.tlast  <= 1'b0;
                            end else if (gap_q == 16'd0) begin
                                m.tdata <= beat(mode_q, frame_nxt[7:0], 16'd0, lfsr_nxt);
                                m.tlast <= (LAST_IDX == 32'd0);
                            end else begin
                                state    <= GAP;
                                gap_cnt  <= gap_q;
                                m.tvalid <= 1'b0;
                                m.tlast  <= 1'b0;
                            end
                        end
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt - 16'd1;
                    if (gap_cnt == 16'd1) begin
                        state    <= RUN;
                        m.tvalid <= 1'b1;
                        m.tdata  <= beat(mode_q, frame_idx[7:0], 16'd0, lfsr);
                        m.tlast  <= (LAST_IDX == 32'd0);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
